rr_fifo_arbiter: RTL and testbench

RR_FIFO_ARBITER -- requirements
Module: rr_fifo_arbiter

---
 rtl/rr_fifo_arbiter_pkg.sv | 13 +
 rtl/rr_pick4.sv | 25 ++
 rtl/rr_fifo_arbiter.sv | 94 +++++++++
 tb/tb_rr_fifo_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin fifo arbiter.
package rr_fifo_arbiter_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int PIPE_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector over four requests.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] idx,
   output logic       vld
);

   logic [1:0] p;

   // Scan far-to-near so the nearest port after last wins.
   always_comb begin
      idx = last;
      vld = 1'b0;
      p   = last;
      for (int k = 4; k >= 1; k--) begin
         p = last + 2'(k);
         if (req[p]) begin
            idx = p;
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Drains four upstream fifos round-robin into one downstream fifo.
module rr_fifo_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_PORTS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_PORTS-1:0]  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_out0,
   input  logic [DATA_WIDTH-1:0] fifo_out1,
   input  logic [DATA_WIDTH-1:0] fifo_out2,
   input  logic [DATA_WIDTH-1:0] fifo_out3,
   input  logic                  down_almost_full,
   input  logic                  down_full,
   output logic [NUM_PORTS-1:0]  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_en_out,
   output logic [1:0]            grant_idx,
   output logic [1:0]            state,
   output logic [7:0]            xfer_count,
   output logic                  overflow_err
);

   import rr_fifo_arbiter_pkg::*;

   arb_state_t            st;
   logic [1:0]            last_grant;
   logic [1:0]            grant_q;
   logic [1:0]            pick;
   logic [1:0]            sel1;
   logic                  pick_vld;
   logic                  pop;
   logic                  any_req;
   logic [NUM_PORTS-1:0]  req;
   logic [PIPE_DEPTH-1:0] vld;
   logic [DATA_WIDTH-1:0] word;

   assign req     = ~fifo_empty;
   assign any_req = |req;

   rr_pick4 u_pick (
      .req  (req),
      .last (last_grant),
      .idx  (pick),
      .vld  (pick_vld)
   );

   assign pop       = pick_vld & ~down_almost_full & ~rst;
   assign grant_idx = pop ? pick : grant_q;
   assign wr_en_out = vld[PIPE_DEPTH-1];
   assign state     = st;

   always_comb begin
      rd_en = '0;
      if (pop) rd_en[pick] = 1'b1;
   end

   always_comb begin
      unique case (sel1)
         2'd0: word = fifo_out0;
         2'd1: word = fifo_out1;
         2'd2: word = fifo_out2;
         2'd3: word = fifo_out3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant   <= 2'd3;
         grant_q      <= 2'd0;
         sel1         <= 2'd0;
         vld          <= '0;
         data_out     <= '0;
         xfer_count   <= 8'd0;
         overflow_err <= 1'b0;
         st           <= IDLE;
      end else begin
         grant_q <= grant_idx;
         vld     <= {vld[PIPE_DEPTH-2:0], pop};
         if (pop) begin
            last_grant <= pick;
            sel1       <= pick;
         end
         // Upstream buf_out is valid the cycle after the pop.
         if (vld[0]) data_out <= word;
         if (wr_en_out) xfer_count <= xfer_count + 8'd1;
         if (wr_en_out && down_full) overflow_err <= 1'b1;
         if (down_almost_full) st <= PAUSE;
         else if (any_req)     st <= ACTIVE;
         else                  st <= IDLE;
      end
   end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed bench for rr_fifo_arbiter with behavioural upstream fifos.
module tb_rr_fifo_arbiter;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    fifo_empty;
   logic [DW-1:0] fifo_out0, fifo_out1, fifo_out2, fifo_out3;
   logic          daf = 1'b0;
   logic          dfull = 1'b0;
   logic [3:0]    rd_en;
   logic [DW-1:0] data_out;
   logic          wr_en_out;
   logic [1:0]    grant_idx;
   logic [1:0]    st;
   logic [7:0]    xfer_count;
   logic          overflow_err;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int k0 = 0;

   logic [3:0]    pop_en[$];
   int            pop_cyc[$];
   logic [DW-1:0] push_dat[$];
   int            push_cyc[$];

   logic [DW-1:0] mem [4][16];
   int unsigned   hd [4] = '{default: 0};
   int unsigned   tl [4] = '{default: 0};
   int unsigned   cnt [4] = '{default: 0};
   logic [DW-1:0] bo [4] = '{default: '0};
   logic [3:0]    ld_en = 4'd0;
   logic [DW-1:0] ld_d [4] = '{default: '0};

   always #5 clk = ~clk;

   rr_fifo_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .fifo_empty       (fifo_empty),
      .fifo_out0        (fifo_out0),
      .fifo_out1        (fifo_out1),
      .fifo_out2        (fifo_out2),
      .fifo_out3        (fifo_out3),
      .down_almost_full (daf),
      .down_full        (dfull),
      .rd_en            (rd_en),
      .data_out         (data_out),
      .wr_en_out        (wr_en_out),
      .grant_idx        (grant_idx),
      .state            (st),
      .xfer_count       (xfer_count),
      .overflow_err     (overflow_err)
   );

   // Upstream fifo8 model: registered buf_out on pop.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd_en[i] && cnt[i] > 0) begin
            bo[i] <= mem[i][hd[i]];
            hd[i] <= (hd[i] + 1) % 16;
         end
         if (ld_en[i]) begin
            mem[i][tl[i]] <= ld_d[i];
            tl[i] <= (tl[i] + 1) % 16;
         end
         cnt[i] <= cnt[i] + (ld_en[i] ? 1 : 0)
                   - ((rd_en[i] && cnt[i] > 0) ? 1 : 0);
      end
   end

   always_comb begin
      fifo_empty = '0;
      for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
   end

   assign fifo_out0 = bo[0];
   assign fifo_out1 = bo[1];
   assign fifo_out2 = bo[2];
   assign fifo_out3 = bo[3];

   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (rd_en != 4'd0) begin
         pop_en.push_back(rd_en);
         pop_cyc.push_back(cyc);
      end
      if (wr_en_out) begin
         push_dat.push_back(data_out);
         push_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      pop_en.delete();
      pop_cyc.delete();
      push_dat.delete();
      push_cyc.delete();
   endtask

   task automatic ld(input logic [3:0] m, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic [DW-1:0] c,
                     input logic [DW-1:0] d);
      @(negedge clk);
      ld_en = m;
      ld_d[0] = a;
      ld_d[1] = b;
      ld_d[2] = c;
      ld_d[3] = d;
      @(negedge clk);
      ld_en = 4'd0;
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr();
   endtask

   task automatic go();
      @(negedge clk);
      daf = 1'b0;
      k0 = cyc;
   endtask

   task automatic chk_logs(input string t, input int n,
                           input int ep[12], input int ec[12],
                           input int ed[12]);
      chk({t, "_npop"}, pop_en.size(), n);
      chk({t, "_npush"}, push_dat.size(), n);
      for (int k = 0; k < n; k++) begin
         if (k < pop_en.size()) begin
            chk($sformatf("%s_pop%0d", t, k), pop_en[k], ep[k]);
            chk($sformatf("%s_pcyc%0d", t, k), pop_cyc[k] - k0, ec[k]);
         end
         if (k < push_dat.size()) begin
            chk($sformatf("%s_dat%0d", t, k), push_dat[k], ed[k]);
            chk($sformatf("%s_wcyc%0d", t, k), push_cyc[k] - k0, ec[k] + 2);
         end
      end
   endtask

   int ep[12];
   int ec[12];
   int ed[12];

   initial begin
      // Reset values, then idle with all ports empty.
      repeat (3) @(negedge clk);
      #3;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr", wr_en_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_xfer", xfer_count, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_state", st, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         #3;
         chk("idle_rd_en", rd_en, 0);
         chk("idle_state", st, 0);
         chk("idle_xfer", xfer_count, 0);
      end

      // Port 0 {1,2}, port 2 {7}.
      daf = 1'b1;
      do_rst();
      ld(4'b0101, 1, 0, 7, 0);
      ld(4'b0001, 2, 0, 0, 0);
      go();
      repeat (8) @(negedge clk);
      #3;
      ep = '{default: 0};
      ec = '{default: 0};
      ed = '{default: 0};
      ep[0] = 1; ep[1] = 4; ep[2] = 1;
      ec[0] = 1; ec[1] = 2; ec[2] = 3;
      ed[0] = 1; ed[1] = 7; ed[2] = 2;
      chk_logs("t2", 3, ep, ec, ed);
      chk("t2_xfer", xfer_count, 3);
      chk("t2_state", st, 0);

      // Four ports, three words each.
      daf = 1'b1;
      do_rst();
      for (int r = 0; r < 3; r++)
         ld(4'b1111, DW'(r), DW'(4 + r), DW'(8 + r), DW'(12 + r));
      go();
      repeat (18) @(negedge clk);
      #3;
      for (int k = 0; k < 12; k++) begin
         ep[k] = 1 << (k % 4);
         ec[k] = k + 1;
         ed[k] = (k % 4) * 4 + k / 4;
      end
      chk_logs("t3", 12, ep, ec, ed);
      chk("t3_xfer", xfer_count, 12);

      // Almost-full pause mid-stream.
      daf = 1'b1;
      do_rst();
      ld(4'b1111, 0, 4, 8, 12);
      ld(4'b1111, 1, 5, 9, 13);
      go();
      @(negedge clk);
      #3;
      chk("t4_state_act", st, 1);
      @(negedge clk);
      daf = 1'b1;
      #3;
      chk("t4_rd_hold", rd_en, 0);
      @(negedge clk);
      #3;
      chk("t4_state_pause", st, 2);
      repeat (2) @(negedge clk);
      @(negedge clk);
      daf = 1'b0;
      repeat (10) @(negedge clk);
      #3;
      ep[0] = 1; ep[1] = 2; ep[2] = 4; ep[3] = 8;
      ep[4] = 1; ep[5] = 2; ep[6] = 4; ep[7] = 8;
      ec[0] = 1; ec[1] = 2;
      for (int k = 2; k < 8; k++) ec[k] = k + 5;
      ed[0] = 0; ed[1] = 4; ed[2] = 8; ed[3] = 12;
      ed[4] = 1; ed[5] = 5; ed[6] = 9; ed[7] = 13;
      chk_logs("t4", 8, ep, ec, ed);
      chk("t4_xfer", xfer_count, 8);
      chk("t4_state_idle", st, 0);

      // Push into a full downstream fifo.
      daf = 1'b1;
      do_rst();
      ld(4'b0010, 0, 3, 0, 0);
      go();
      dfull = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #3;
      chk("t5_wr", wr_en_out, 1);
      chk("t5_ovf_pre", overflow_err, 0);
      @(negedge clk);
      dfull = 1'b0;
      #3;
      chk("t5_ovf_set", overflow_err, 1);
      repeat (5) @(negedge clk);
      #3;
      chk("t5_ovf_sticky", overflow_err, 1);
      @(negedge clk);
      rst = 1'b1;
      #3;
      chk("t5_ovf_clr", overflow_err, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset with two words in flight.
      daf = 1'b1;
      ld(4'b0110, 0, 3, 4, 0);
      go();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      clr();
      #3;
      chk("t6_rst_wr", wr_en_out, 0);
      chk("t6_rst_rd", rd_en, 0);
      ld(4'b1001, 5, 0, 0, 6);
      @(negedge clk);
      rst = 1'b0;
      k0 = cyc;
      repeat (8) @(negedge clk);
      #3;
      ep[0] = 1; ep[1] = 8;
      ec[0] = 1; ec[1] = 2;
      ed[0] = 5; ed[1] = 6;
      chk_logs("t6", 2, ep, ec, ed);
      chk("t6_xfer", xfer_count, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
